// File: rtl/id_stage_pkg.sv
// rtl/id_stage_pkg.sv - shared widths, opcodes, ALUOp encodings and control decode for the ID stage
// Contents: LENGTH/ALU_OP_LENGTH defaults, MIPS opcode constants, ALUOp classes,
// ctrl_t control bundle and the decode() helper used by id_stage.
package id_stage_pkg;

    localparam int LENGTH_DEF        = 32;
    localparam int ALU_OP_LENGTH_DEF = 2;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       write_reg_mux;
        logic       memwrite;
        logic       memread;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [5:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_RTYPE: begin
                c.reg_dst  = 1'b1;
                c.regwrite = 1'b1;
                c.alu_op   = ALUOP_FUNCT;
            end
            OP_LW: begin
                c.alusrc        = 1'b1;
                c.memread       = 1'b1;
                c.write_reg_mux = 1'b1;
                c.regwrite      = 1'b1;
                c.alu_op        = ALUOP_ADD;
            end
            OP_SW: begin
                c.alusrc   = 1'b1;
                c.memwrite = 1'b1;
                c.alu_op   = ALUOP_ADD;
            end
            OP_BEQ: begin
                c.alu_op = ALUOP_SUB;
            end
            OP_ADDI: begin
                c.alusrc   = 1'b1;
                c.regwrite = 1'b1;
                c.alu_op   = ALUOP_ADD;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// rtl/id_stage_regfile.sv - 32-entry register file, two combinational read ports, one write port
// Ports: clk, rst (async active-low, clears all entries), we/waddr/wdata (write port),
// raddr1/raddr2 -> rdata1/rdata2 (zero-latency reads, r0 always reads 0).
// Option: REGFILE_BYPASS_EN forwards same-cycle write data to a matching read port.
module regfile
    import id_stage_pkg::*;
#(
    parameter int LENGTH = LENGTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [LENGTH-1:0] wdata,
    input  logic [4:0]        raddr1,
    input  logic [4:0]        raddr2,
    output logic [LENGTH-1:0] rdata1,
    output logic [LENGTH-1:0] rdata2
);

    logic [LENGTH-1:0] mem [32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != 5'd0) begin
`ifdef REGFILE_BYPASS_EN
            if (we && (raddr1 == waddr)) rdata1 = wdata;
            else                         rdata1 = mem[raddr1];
`else
            rdata1 = mem[raddr1];
`endif
        end
        if (raddr2 != 5'd0) begin
`ifdef REGFILE_BYPASS_EN
            if (we && (raddr2 == waddr)) rdata2 = wdata;
            else                         rdata2 = mem[raddr2];
`else
            rdata2 = mem[raddr2];
`endif
        end
    end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - pipeline decode stage: control decode, register file, load-use hazard, stall counter
// Ports: clk, rst (async active-low); instr from IF/ID; wb_RegWrite/wb_write_reg/wb_write_data
// writeback; ex_Memread/ex_rt from ID/EX; control outputs, ALUOp, Read_data_1/2, imm_ext,
// rs/rt/rd, stall, bubble, stall_cnt (saturating count of load-use stall cycles).
// Option: REGFILE_BYPASS_EN (inside regfile) enables same-cycle write-to-read forwarding.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int LENGTH        = LENGTH_DEF,
    parameter int ALU_OP_LENGTH = ALU_OP_LENGTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              instr,
    input  logic                     wb_RegWrite,
    input  logic [4:0]               wb_write_reg,
    input  logic [LENGTH-1:0]        wb_write_data,
    input  logic                     ex_Memread,
    input  logic [4:0]               ex_rt,
    output logic                     RegDst,
    output logic                     Write_reg_mux,
    output logic                     Memwrite,
    output logic                     Memread,
    output logic                     ALUsrc,
    output logic                     RegWrite,
    output logic [ALU_OP_LENGTH-1:0] ALUOp,
    output logic [LENGTH-1:0]        Read_data_1,
    output logic [LENGTH-1:0]        Read_data_2,
    output logic [LENGTH-1:0]        imm_ext,
    output logic [4:0]               rs,
    output logic [4:0]               rt,
    output logic [4:0]               rd,
    output logic                     stall,
    output logic                     bubble,
    output logic [15:0]              stall_cnt
);

    ctrl_t ctrl;

    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign imm_ext = {{(LENGTH-16){instr[15]}}, instr[15:0]};

    // Load in EX whose destination feeds this instruction: hold one cycle.
    // r0 is never a real dependency since it always reads 0.
    assign stall  = ex_Memread && (ex_rt != 5'd0) && ((ex_rt == rs) || (ex_rt == rt));
    assign bubble = stall;

    always_comb begin
        ctrl = decode(instr[31:26]);
        if (stall) ctrl = '0;
    end

    assign RegDst        = ctrl.reg_dst;
    assign Write_reg_mux = ctrl.write_reg_mux;
    assign Memwrite      = ctrl.memwrite;
    assign Memread       = ctrl.memread;
    assign ALUsrc        = ctrl.alusrc;
    assign RegWrite      = ctrl.regwrite;
    assign ALUOp         = ALU_OP_LENGTH'(ctrl.alu_op);

    // Writeback is independent of stall: the older instruction must still retire.
    regfile #(
        .LENGTH (LENGTH)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_RegWrite),
        .waddr  (wb_write_reg),
        .wdata  (wb_write_data),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (Read_data_1),
        .rdata2 (Read_data_2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage with directed vectors
`timescale 1ns/1ps
module tb_id_stage;

    localparam int SEL_RD1   = 0;
    localparam int SEL_RD2   = 1;
    localparam int SEL_IMM   = 2;
    localparam int SEL_CTRL  = 3;
    localparam int SEL_STALL = 4;
    localparam int SEL_BUB   = 5;
    localparam int SEL_CNT   = 6;
    localparam int SEL_RS    = 7;
    localparam int SEL_RT    = 8;
    localparam int SEL_RD    = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        wb_RegWrite;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        ex_Memread;
    logic [4:0]  ex_rt;
    logic        RegDst, Write_reg_mux, Memwrite, Memread, ALUsrc, RegWrite;
    logic [1:0]  ALUOp;
    logic [31:0] Read_data_1, Read_data_2, imm_ext;
    logic [4:0]  rs, rt, rd;
    logic        stall, bubble;
    logic [15:0] stall_cnt;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .wb_RegWrite   (wb_RegWrite),
        .wb_write_reg  (wb_write_reg),
        .wb_write_data (wb_write_data),
        .ex_Memread    (ex_Memread),
        .ex_rt         (ex_rt),
        .RegDst        (RegDst),
        .Write_reg_mux (Write_reg_mux),
        .Memwrite      (Memwrite),
        .Memread       (Memread),
        .ALUsrc        (ALUsrc),
        .RegWrite      (RegWrite),
        .ALUOp         (ALUOp),
        .Read_data_1   (Read_data_1),
        .Read_data_2   (Read_data_2),
        .imm_ext       (imm_ext),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .stall         (stall),
        .bubble        (bubble),
        .stall_cnt     (stall_cnt)
    );

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            SEL_RD1:   return Read_data_1;
            SEL_RD2:   return Read_data_2;
            SEL_IMM:   return imm_ext;
            SEL_CTRL:  return {24'd0, RegDst, Write_reg_mux, Memwrite, Memread, ALUsrc, RegWrite, ALUOp};
            SEL_STALL: return {31'd0, stall};
            SEL_BUB:   return {31'd0, bubble};
            SEL_CNT:   return {16'd0, stall_cnt};
            SEL_RS:    return {27'd0, rs};
            SEL_RT:    return {27'd0, rt};
            SEL_RD:    return {27'd0, rd};
            default:   return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: outputs are combinational/registered and settle before the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            chk_t e;
            logic [31:0] a;
            e = sb.pop_front();
            a = actual(e.sel);
            n_total++;
            if (a === e.exp) n_pass++;
            else $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
        end
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s,
                                       input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    task automatic expect_val(input string name, input int sel, input logic [31:0] v);
        chk_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
        wb_RegWrite   = en;
        wb_write_reg  = r;
        wb_write_data = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        instr = 32'd0;
        ex_Memread = 1'b0;
        ex_rt = 5'd0;
        wb(1'b1, 5'd7, 32'h0000_00FF);
        step();
        expect_val("cnt_in_reset", SEL_CNT, 32'd0);
        step();
        wb(1'b0, 5'd0, 32'd0);
        rst = 1'b1;

        for (int r = 1; r < 32; r++) begin
            instr = mk(6'b000000, 5'(r), 5'(r), 16'd0);
            expect_val($sformatf("rst_r%0d", r), SEL_RD1, 32'd0);
            step();
        end
        expect_val("cnt_after_reset", SEL_CNT, 32'd0);

        wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        step();
        wb(1'b1, 5'd0, 32'h0000_0001);
        instr = mk(6'b000000, 5'd5, 5'd0, 16'd0);
        expect_val("r5_read", SEL_RD1, 32'hDEAD_BEEF);
        step();
        wb(1'b1, 5'd9, 32'h1234_5678);
        step();
        wb(1'b0, 5'd0, 32'd0);
        instr = mk(6'b000000, 5'd0, 5'd9, 16'd0);
        expect_val("r0_zero", SEL_RD1, 32'd0);
        expect_val("r9_rt", SEL_RD2, 32'h1234_5678);
        step();

        instr = mk(6'b000000, 5'd8, 5'd9, {5'd10, 11'd0});
        expect_val("ctrl_rtype", SEL_CTRL, 32'h86);
        expect_val("rs_field", SEL_RS, 32'd8);
        expect_val("rt_field", SEL_RT, 32'd9);
        expect_val("rd_field", SEL_RD, 32'd10);
        step();
        instr = mk(6'b100011, 5'd1, 5'd2, 16'h8000);
        expect_val("ctrl_lw", SEL_CTRL, 32'h5C);
        expect_val("imm_neg", SEL_IMM, 32'hFFFF_8000);
        step();
        instr = mk(6'b101011, 5'd1, 5'd2, 16'h0004);
        expect_val("ctrl_sw", SEL_CTRL, 32'h28);
        step();
        instr = mk(6'b000100, 5'd1, 5'd2, 16'h0004);
        expect_val("ctrl_beq", SEL_CTRL, 32'h01);
        step();
        instr = mk(6'b001000, 5'd1, 5'd2, 16'h7FFF);
        expect_val("ctrl_addi", SEL_CTRL, 32'h0C);
        expect_val("imm_pos", SEL_IMM, 32'h0000_7FFF);
        step();
        instr = mk(6'b111111, 5'd1, 5'd2, 16'h0000);
        expect_val("ctrl_illegal", SEL_CTRL, 32'h00);
        step();

        ex_Memread = 1'b1;
        ex_rt = 5'd8;
        instr = mk(6'b000000, 5'd8, 5'd9, 16'd0);
        expect_val("stall_rs", SEL_STALL, 32'd1);
        expect_val("bubble_rs", SEL_BUB, 32'd1);
        expect_val("ctrl_stalled", SEL_CTRL, 32'h00);
        expect_val("rs_stalled", SEL_RS, 32'd8);
        step();
        ex_rt = 5'd9;
        expect_val("stall_rt", SEL_STALL, 32'd1);
        step();
        ex_rt = 5'd7;
        expect_val("stall_nomatch", SEL_STALL, 32'd0);
        step();
        ex_rt = 5'd0;
        instr = mk(6'b000000, 5'd0, 5'd0, 16'd0);
        expect_val("stall_r0", SEL_STALL, 32'd0);
        expect_val("ctrl_r0", SEL_CTRL, 32'h86);
        step();
        ex_Memread = 1'b0;
        ex_rt = 5'd8;
        instr = mk(6'b000000, 5'd8, 5'd9, 16'd0);
        expect_val("stall_nomemread", SEL_STALL, 32'd0);
        step();

        rst = 1'b0;
        step();
        rst = 1'b1;
        ex_Memread = 1'b1;
        ex_rt = 5'd8;
        instr = mk(6'b000000, 5'd8, 5'd4, 16'd0);
        wb(1'b1, 5'd4, 32'h0000_A5A5);
        expect_val("cnt_start", SEL_CNT, 32'd0);
        expect_val("stall_wb", SEL_STALL, 32'd1);
        step();
        wb(1'b0, 5'd0, 32'd0);
        expect_val("wb_during_stall", SEL_RD2, 32'h0000_A5A5);
        expect_val("cnt_1", SEL_CNT, 32'd1);
        step();
        step();
        step();
        step();
        expect_val("cnt_5", SEL_CNT, 32'd5);
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
        end
        #1;
        expect_val("cnt_sat", SEL_CNT, 32'h0000_FFFF);
        step();
        expect_val("cnt_hold_sat", SEL_CNT, 32'h0000_FFFF);
        step();
        rst = 1'b0;
        #1;
        expect_val("cnt_async_clr", SEL_CNT, 32'd0);
        expect_val("rf_async_clr", SEL_RD2, 32'd0);
        step();
        expect_val("cnt_held_in_reset", SEL_CNT, 32'd0);
        step();
        rst = 1'b1;
        ex_Memread = 1'b0;

        wb(1'b1, 5'd3, 32'h0000_0011);
        step();
        wb(1'b1, 5'd3, 32'h0000_0055);
        instr = mk(6'b000000, 5'd3, 5'd0, 16'd0);
`ifdef REGFILE_BYPASS_EN
        expect_val("same_cycle_r3", SEL_RD1, 32'h0000_0055);
`else
        expect_val("same_cycle_r3", SEL_RD1, 32'h0000_0011);
`endif
        step();
        wb(1'b1, 5'd0, 32'h0000_0077);
        expect_val("next_cycle_r3", SEL_RD1, 32'h0000_0055);
        instr = mk(6'b000000, 5'd3, 5'd0, 16'd0);
        expect_val("bypass_r0", SEL_RD2, 32'd0);
        step();
        wb(1'b0, 5'd0, 32'd0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
